// File: rtl/cy_control_bank_pkg.sv
// Shared constants for the control-register bank: bit modes, bus
// addresses and the pulse counter width.
package cy_control_bank_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_SYNC   = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_PULSE  = 2'd3;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_SET    = 2'd1;
  localparam logic [1:0] ADDR_CLR    = 2'd2;
  localparam logic [1:0] ADDR_COMMIT = 2'd3;

  localparam int PulseCntWidth = 8;

  // One bit per control bit, set where that bit is in pulse mode.
  function automatic logic [31:0] pulse_mask(input logic [63:0] bit_mode);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (bit_mode[2*i +: 2] == MODE_PULSE);
    end
    return m;
  endfunction

endpackage

// File: rtl/cy_control_bit_cell.sv
// One control output bit: sync flop, toggle flop, pulse counter and the
// mode mux that picks which of them drives the output.
module cy_control_bit_cell
  import cy_control_bank_pkg::*;
#(
  parameter logic [1:0] Mode       = MODE_DIRECT,
  parameter logic       InitValue  = 1'b0,
  parameter int         PulseWidth = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic commit_evt,
  input  logic sh_bit,
  input  logic ac_bit,
  output logic control,
  output logic busy
);

  localparam logic [PulseCntWidth-1:0] PulseLoad = PulseCntWidth'(PulseWidth);
  localparam logic [PulseCntWidth-1:0] CntOne    = PulseCntWidth'(1);

  logic                     sync_q;
  logic                     toggle_q;
  logic [PulseCntWidth-1:0] cnt_q;
  logic                     fire;

  // A commit only acts on toggle/pulse bits whose shadow bit is set.
  assign fire = commit_evt & sh_bit;
  assign busy = (cnt_q != '0);

  // Sync mode: active bit re-registered once.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= InitValue;
    else       sync_q <= ac_bit;
  end

  // Toggle mode: invert on every firing commit.
  always_ff @(posedge clock) begin
    if (reset)                            toggle_q <= InitValue;
    else if (fire && Mode == MODE_TOGGLE) toggle_q <= ~toggle_q;
  end

  // Pulse mode: load on fire (also retriggers mid-pulse), count down to zero.
  always_ff @(posedge clock) begin
    if (reset)                           cnt_q <= '0;
    else if (fire && Mode == MODE_PULSE) cnt_q <= PulseLoad;
    else if (cnt_q != '0)                cnt_q <= cnt_q - CntOne;
  end

  // Output mux, fixed per bit at elaboration.
  always_comb begin
    control = ac_bit;
    case (Mode)
      MODE_SYNC:   control = sync_q;
      MODE_TOGGLE: control = toggle_q;
      MODE_PULSE:  control = busy;
      default:     control = ac_bit;
    endcase
  end

endmodule

// File: rtl/cy_control_bank.sv
// Control-register bank: shadow/active registers, commit merge, read mux
// and one bit cell per live output.
module cy_control_bank
  import cy_control_bank_pkg::*;
#(
  parameter int          NumOutputs = 8,
  parameter logic [63:0] BitMode    = 64'h0,
  parameter logic [31:0] BitValue   = 32'h0,
  parameter int          PulseWidth = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            addr,
  input  logic [NumOutputs-1:0] wr_data,
  input  logic                  rd_en,
  output logic [NumOutputs-1:0] rd_data,
  input  logic                  commit,
  output logic [NumOutputs-1:0] control,
  output logic                  pulse_busy
);

  localparam logic [31:0]           PulseMaskAll = pulse_mask(BitMode);
  localparam logic [NumOutputs-1:0] PulseMask    = PulseMaskAll[NumOutputs-1:0];
  localparam logic [NumOutputs-1:0] ResetShadow  = BitValue[NumOutputs-1:0] & ~PulseMask;

  logic [NumOutputs-1:0] sh_q;
  logic [NumOutputs-1:0] sh_d;
  logic [NumOutputs-1:0] ac_q;
  logic [NumOutputs-1:0] busy_vec;
  logic                  commit_evt;

  // Bus and fabric commits in the same cycle merge into one.
  assign commit_evt = commit | (wr_en && addr == ADDR_COMMIT);
  assign pulse_busy = |busy_vec;

  // Shadow next value: pulse bits self-clear on commit, then any write lands on top.
  always_comb begin
    sh_d = sh_q;
    if (commit_evt) sh_d = sh_q & ~PulseMask;
    if (wr_en) begin
      case (addr)
        ADDR_DATA: sh_d = wr_data;
        ADDR_SET:  sh_d = sh_d | wr_data;
        ADDR_CLR:  sh_d = sh_d & ~wr_data;
        default:   ;
      endcase
    end
  end

  // Shadow and active registers; commit copies the pre-write shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q <= ResetShadow;
      ac_q <= ResetShadow;
    end else begin
      sh_q <= sh_d;
      if (commit_evt) ac_q <= sh_q;
    end
  end

  // Registered read: 0 shadow, 1 active, 2 outputs, 3 pulse busy mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      case (addr)
        2'd0:    rd_data <= sh_q;
        2'd1:    rd_data <= ac_q;
        2'd2:    rd_data <= control;
        default: rd_data <= busy_vec;
      endcase
    end
  end

  for (genvar i = 0; i < NumOutputs; i++) begin : g_bit
    cy_control_bit_cell #(
      .Mode       (BitMode[2*i +: 2]),
      .InitValue  (BitValue[i]),
      .PulseWidth (PulseWidth)
    ) u_cell (
      .clock      (clock),
      .reset      (reset),
      .commit_evt (commit_evt),
      .sh_bit     (sh_q[i]),
      .ac_bit     (ac_q[i]),
      .control    (control[i]),
      .busy       (busy_vec[i])
    );
  end

endmodule
